// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the core's fetch/data request ports, the arbiter and the unified memory.
// The arbiter binds to the slave modport; the core/memory side binds to master.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
// Optional MEM_BUS_ARB_ROUND_ROBIN_EN: contended grants alternate instead of data-over-fetch.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_bus_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;

  logic can_grant, d_win, accept, we_legal;

  // Handshake: a request (req plus its address/data) is held by the requester until gnt;
  // gnt is combinational and the transaction is accepted on the clock edge ending that cycle.
  // rvalid is a single-cycle pulse with no back-pressure; rdata is only meaningful with it.
  assign can_grant = (state_q == IDLE) || (state_q == RESP);

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
  owner_t last_owner_q, last_owner_d;

  assign d_win = bus.d_req && (!bus.i_req || (last_owner_q == OWN_FETCH));
  assign last_owner_d = accept ? (bus.d_gnt ? OWN_DATA : OWN_FETCH) : last_owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_owner_q <= OWN_FETCH;
    else        last_owner_q <= last_owner_d;
  end
`else
  assign d_win = bus.d_req;
`endif

  assign bus.d_gnt = can_grant && d_win;
  assign bus.i_gnt = can_grant && bus.i_req && !d_win;
  assign accept    = bus.d_gnt || bus.i_gnt;
  assign we_legal  = (bus.d_we == 3'b100) || (bus.d_we == 3'b010) || (bus.d_we == 3'b001);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 3'b000;
    mem_wdata_d = mem_wdata_q;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          if (owner_q == OWN_DATA) d_rvalid_d = 1'b1;
          else                     i_rvalid_d = 1'b1;
        end
      end
      RESP: begin
        state_d = accept ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cnt_d = 3'(MEM_LATENCY);
      if (bus.d_gnt) begin
        owner_d     = OWN_DATA;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
        mem_we_d    = we_legal ? bus.d_we : 3'b000;
      end else begin
        owner_d    = OWN_FETCH;
        mem_addr_d = bus.i_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      cnt_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_we_q    <= 3'b000;
      mem_wdata_q <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic, checked each cycle
// against a transaction-level model (grant window, response cycle, register contents).
module tb_mem_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // stimulus for the next cycle
  logic        s_rst, s_ireq, s_dreq;
  logic [31:0] s_iaddr, s_daddr, s_dwdata;
  logic [2:0]  s_dwe;

  // reference model: time-based view of the single outstanding transaction
  int          cyc = 0;
  int          next_free = 0;   // first cycle in which a grant may be given
  int          resp_cyc = -1;   // cycle in which the response pulse is due
  logic        resp_data = 1'b0;
  logic        last_data = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [2:0]  exp_we = '0;

  task automatic step();
    logic        free, dwin, ig, dg;
    logic [31:0] rd;
    @(negedge clk);
    rst_n        = s_rst;
    bus.i_req    = s_rst & s_ireq;
    bus.i_addr   = s_iaddr;
    bus.d_req    = s_rst & s_dreq;
    bus.d_addr   = s_daddr;
    bus.d_we     = s_dwe;
    bus.d_wdata  = s_dwdata;
    rd           = $urandom;
    bus.mem_rdata = rd;
    #1;
    if (!s_rst) begin
      next_free = 0; resp_cyc = -1; last_data = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_we = '0;
    end
    free = s_rst && (cyc >= next_free);
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    dwin = bus.d_req && (!bus.i_req || !last_data);
`else
    dwin = bus.d_req;
`endif
    dg = free && dwin;
    ig = free && bus.i_req && !dwin;

    check("i_gnt",     32'(bus.i_gnt),    32'(ig));
    check("d_gnt",     32'(bus.d_gnt),    32'(dg));
    check("mem_addr",  bus.mem_addr,      exp_addr);
    check("mem_we",    32'(bus.mem_we),   32'(exp_we));
    check("mem_wdata", bus.mem_wdata,     exp_wdata);
    check("i_rvalid",  32'(bus.i_rvalid), 32'((cyc == resp_cyc) && !resp_data));
    check("d_rvalid",  32'(bus.d_rvalid), 32'((cyc == resp_cyc) && resp_data));
    check("i_rdata",   bus.i_rdata,       rd);
    check("d_rdata",   bus.d_rdata,       rd);

    exp_we = 3'b000;
    if (dg || ig) begin
      next_free = cyc + 1 + LAT;
      resp_cyc  = cyc + 1 + LAT;
      resp_data = dg;
      last_data = dg;
      if (dg) begin
        exp_addr  = bus.d_addr;
        exp_wdata = bus.d_wdata;
        exp_we    = (bus.d_we == 3'b100 || bus.d_we == 3'b010 || bus.d_we == 3'b001) ? bus.d_we : 3'b000;
      end else begin
        exp_addr = bus.i_addr;
      end
    end
    cyc++;
  endtask

  // driver: hold one input pattern for n cycles
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da, input logic [2:0] we,
                       input logic [31:0] wd, input int n);
    s_rst = r; s_ireq = ir; s_iaddr = ia; s_dreq = dr; s_daddr = da; s_dwe = we; s_dwdata = wd;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
    bus.d_we = 3'b000; bus.d_wdata = '0; bus.mem_rdata = '0;

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 3);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 2);
    // fetch, then idle through the response
    drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 3'b000, 32'h0, 1);
    drive(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 3'b000, 32'h0, LAT + 2);
    // word store
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 3'b001, 32'hDEADBEEF, 1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h100, 3'b001, 32'hDEADBEEF, LAT + 2);
    // both requesters held continuously
    drive(1'b1, 1'b1, 32'h44, 1'b1, 32'h88, 3'b000, 32'h0, 5 * (LAT + 1));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, LAT + 2);
    // load with fetch waiting behind it
    drive(1'b1, 1'b1, 32'h30, 1'b1, 32'h20, 3'b000, 32'h0, 1);
    drive(1'b1, 1'b1, 32'h30, 1'b0, 32'h20, 3'b000, 32'h0, LAT + 3);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, LAT + 2);
    // half store interrupted by reset in its access phase
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 3'b010, 32'h12345678, 1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 2);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, LAT + 2);
    drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 3'b000, 32'h0, 1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, LAT + 2);
    // illegal write-enable behaves as a read
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 3'b011, 32'hCAFEF00D, 1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, LAT + 2);

    // random traffic with occasional resets and dropped requests
    for (int i = 0; i < 3000; i++) begin
      s_rst    = ($urandom_range(0, 199) != 0);
      s_ireq   = ($urandom_range(0, 2) != 0);
      s_dreq   = ($urandom_range(0, 2) != 0);
      s_iaddr  = $urandom;
      s_daddr  = $urandom;
      s_dwe    = 3'($urandom_range(0, 7));
      s_dwdata = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Sequences and shares the single-port unified memory between the core's instruction-fetch port and its load/store data port. It accepts one request at a time, drives the memory address, write-enable and write data, and waits a fixed read latency. It then returns a one-cycle response to whichever requester won. It sits between the multi-cycle core and the memory/GPIO block, replacing the direct iaddr/addr wiring.

Parameters:
ADDR_W, 32, width of all address buses
DATA_W, 32, width of all data buses
MEM_LATENCY, 1, cycles from mem_addr driven to mem_rdata valid; legal 1..4

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted this cycle (combinational)
i_rvalid  out  1  fetch response valid, one-cycle pulse
i_rdata  out  DATA_W  fetch data, valid when i_rvalid
d_req  in  1  data request; held with d_addr/d_we/d_wdata until d_gnt
d_addr  in  ADDR_W  data address
d_we  in  3  write enable: 100 byte, 010 half, 001 word, 000 read
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  data response / write completion, one-cycle pulse
d_rdata  out  DATA_W  load data, valid when d_rvalid
mem_addr  out  ADDR_W  memory address, registered
mem_we  out  3  memory write enable, registered, same encoding as d_we
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE, mem_addr 0, mem_we 000, mem_wdata 0, i_rvalid/d_rvalid 0, cnt 0, owner = fetch, last_owner = fetch.
- States: IDLE, ACCESS, RESP. Only one transaction is outstanding at a time.
- Grant: gnt is asserted only in IDLE or RESP, and only to the winner among asserted requests. Default priority is data over fetch. At most one gnt per cycle, and gnt never asserts without req.
- On the accept edge:
  - mem_addr is loaded from the winner's address.
  - mem_wdata is loaded from d_wdata (data winner) or left unchanged (fetch winner).
  - mem_we is loaded from d_we (data winner) or 000 (fetch winner).
  - owner is loaded with the winner, cnt is loaded with MEM_LATENCY, and the next state is ACCESS.
- d_we values other than 100/010/001 are treated as reads (mem_we 000).
- ACCESS:
  - mem_we is cleared on the first edge in ACCESS, so it is high for exactly one cycle.
  - cnt decrements on each edge.
  - When cnt==1 at the edge, the next state is RESP and the owner's rvalid is set to 1.
  - ACCESS lasts exactly MEM_LATENCY cycles.
- RESP (one cycle):
  - The owner's rvalid is 1 and its rdata equals mem_rdata (combinational pass-through). The non-owner's rvalid is 0.
  - rvalid is cleared at the end of the cycle.
  - A new request may be granted in this cycle, giving back-to-back transactions. With no request, the next state is IDLE.
- Latency: gnt in cycle 0 → mem_addr valid in cycle 1 → rvalid in cycle 1+MEM_LATENCY. Writes also pulse d_rvalid in cycle 1+MEM_LATENCY as completion; d_rdata is don't-care then.
- mem_addr and mem_wdata hold their values between transactions.
- i_rdata and d_rdata both equal mem_rdata at all times; only rvalid qualifies them.
- Requests dropped before gnt are legal and are simply not served.
- Reset mid-transaction: all outputs return immediately to reset values. The in-flight transaction is discarded and no rvalid is issued for it.
- Address alignment is not checked; it is passed through unchanged.

Optional Feature:
MEM_BUS_ARB_ROUND_ROBIN_EN:
- Defined: when both requests are asserted in a grant cycle, the port that did not win the previous grant wins. last_owner updates on every accept.
- From reset (last_owner = fetch), the first contended grant goes to data.
- Undefined: fixed data-over-fetch priority; last_owner is unused.

Test Plan:
1. MEM_LATENCY=1, i_req with i_addr=0x10, memory returns 0x00500093 → i_gnt in cycle 0, mem_addr=0x10 in cycle 1, i_rvalid=1 with i_rdata=0x00500093 in cycle 2 only, mem_we=000 throughout.
2. d_req store: d_addr=0x100, d_we=001, d_wdata=0xDEADBEEF → mem_we=001 for exactly cycle 1 with mem_wdata=0xDEADBEEF, d_rvalid in cycle 2, i_rvalid stays 0.
3. i_req and d_req both held continuously, feature off → d_gnt on every grant, i_gnt never. Feature on → grants alternate d,i,d,i, with one grant every 2 cycles at MEM_LATENCY=1.
4. MEM_LATENCY=3, d_req load at 0x20 → d_rvalid in cycle 4, no gnt in cycles 1-3 even with i_req held, i_gnt in cycle 4.
5. rst_n pulled low in the ACCESS cycle of a d_we=010 store → mem_we=000 and d_rvalid=0 immediately and for all following cycles. After release, a new i_req is granted from IDLE.
6. d_we=011 with d_req → treated as read, mem_we=000 in cycle 1, d_rvalid in cycle 2.
